// File: rtl/tlb_regfile_pkg.sv
// tlb_regfile_pkg -- shared TLB sizing, types and entry field layout.
//
// Packed entry layout (TLB_ENTRY_WIDTH bits):
//   [31:0]  {VPN2[31:13], 5'b0, ASID[7:0]}
//   [63:32] EntryLo0 word, bit 32 holds the combined global bit
//   [95:64] EntryLo1 word, bit 64 holds the same combined global bit
package tlb_regfile_pkg;

    localparam int unsigned TLB_ENTRY_NUM   = 16;
    localparam int unsigned TLB_ENTRY_WIDTH = 96;
    localparam int unsigned TLB_INDEX_WIDTH = 4;

    // Field offsets inside a packed entry
    localparam int unsigned HI_LSB    = 0;
    localparam int unsigned LO0_LSB   = 32;
    localparam int unsigned LO1_LSB   = 64;
    localparam int unsigned G_BIT     = LO0_LSB;
    localparam int unsigned VPN2_MSB  = 31;
    localparam int unsigned VPN2_LSB  = 13;
    localparam int unsigned ASID_MSB  = 7;
    localparam int unsigned ASID_LSB  = 0;

    typedef logic [31:0]                                       Word_t;
    typedef logic [TLB_INDEX_WIDTH-1:0]                        TLB_index_t;
    typedef logic [TLB_ENTRY_WIDTH-1:0]                        TLB_entry_t;
    typedef logic [TLB_ENTRY_NUM-1:0][TLB_ENTRY_WIDTH-1:0]     TLB_entries_t;

    localparam TLB_index_t RANDOM_TOP = TLB_index_t'(TLB_ENTRY_NUM - 1);

    // An entry is global only when both halves are global.
    function automatic TLB_entry_t pack_entry(input Word_t hi, input Word_t lo0, input Word_t lo1);
        logic g;
        g = lo0[0] & lo1[0];
        return {lo1[31:1], g, lo0[31:1], g, hi[31:13], 5'b0, hi[7:0]};
    endfunction

    // Read-back form of an EntryLo word: {6'b0, PFN, C, D, V, G}.
    function automatic Word_t unpack_lo(input Word_t stored);
        return {6'b0, stored[25:0]};
    endfunction

endpackage

// File: rtl/tlb_regfile_probe_match.sv
// tlb_probe_match -- TLBP comparator and priority encoder (combinational).
//
// Ports:
//   entries  in   all packed TLB entries
//   key      in   probe EntryHi {VPN2[31:13], ASID[7:0]}
//   hit      out  at least one entry matches
//   index    out  lowest matching index (0 when no match)
module tlb_probe_match
    import tlb_regfile_pkg::*;
(
    input  TLB_entries_t entries,
    input  Word_t        key,
    output logic         hit,
    output TLB_index_t   index
);

    logic unused_key_bits;
    assign unused_key_bits = ^key[12:8];

    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int unsigned i = 0; i < TLB_ENTRY_NUM; i++) begin
            if (!hit
                && entries[i][VPN2_MSB:VPN2_LSB] == key[VPN2_MSB:VPN2_LSB]
                && (entries[i][ASID_MSB:ASID_LSB] == key[ASID_MSB:ASID_LSB]
                    || entries[i][G_BIT])) begin
                hit   = 1'b1;
                index = TLB_index_t'(i);
            end
        end
    end

endmodule

// File: rtl/tlb_regfile.sv
// tlb_regfile -- CP0 TLB entry storage with TLBWI/TLBWR/TLBR/TLBP and Random/Wired.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   we, wr_random, wr_index    write request; target is random_o or wr_index
//   wr_hi, wr_lo0, wr_lo1      EntryHi/EntryLo0/EntryLo1 to write
//   wired_we, wired_i          Wired register update
//   rd_req, rd_index           TLBR request -> rd_valid, rd_hi, rd_lo0, rd_lo1 (1 cycle)
//   probe_req, probe_hi        TLBP request -> probe_valid, probe_miss, probe_index (1 cycle)
//   random_o                   CP0 Random
//   entries_o                  packed entries for translation lookup
//
// Build option: define TLB_WIRED_EN to enable the Wired register; otherwise
// Wired is 0, wired_we is ignored and Random cycles 15..0.
module tlb_regfile
    import tlb_regfile_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic         wr_random,
    input  TLB_index_t   wr_index,
    input  Word_t        wr_hi,
    input  Word_t        wr_lo0,
    input  Word_t        wr_lo1,
    input  logic         wired_we,
    input  TLB_index_t   wired_i,
    input  logic         rd_req,
    input  TLB_index_t   rd_index,
    output logic         rd_valid,
    output Word_t        rd_hi,
    output Word_t        rd_lo0,
    output Word_t        rd_lo1,
    input  logic         probe_req,
    input  Word_t        probe_hi,
    output logic         probe_valid,
    output logic         probe_miss,
    output TLB_index_t   probe_index,
    output TLB_index_t   random_o,
    output TLB_entries_t entries_o
);

    TLB_entries_t entries_q;
    TLB_index_t   random_q;
    TLB_index_t   wired_q;
    logic         wired_load;
    TLB_index_t   wr_target;
    logic         match_hit;
    TLB_index_t   match_index;

`ifdef TLB_WIRED_EN
    assign wired_load = wired_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wired_q <= '0;
        else if (wired_we)
            wired_q <= wired_i;
    end
`else
    logic unused_wired;
    assign unused_wired = wired_we ^ (^wired_i);
    assign wired_load   = 1'b0;
    assign wired_q      = '0;
`endif

    // Random reloads to the top when it reaches Wired, so with Wired = 15 it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            random_q <= RANDOM_TOP;
        else if (wired_load || random_q == wired_q)
            random_q <= RANDOM_TOP;
        else
            random_q <= random_q - TLB_index_t'(1);
    end

    // TLBWR uses the Random value of the request cycle, before it advances.
    assign wr_target = wr_random ? random_q : wr_index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            entries_q <= '0;
        else if (we)
            entries_q[wr_target] <= pack_entry(wr_hi, wr_lo0, wr_lo1);
    end

    // Reads and probes sample entries_q before this edge's write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_hi    <= '0;
            rd_lo0   <= '0;
            rd_lo1   <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_hi  <= entries_q[rd_index][LO0_LSB-1:HI_LSB];
                rd_lo0 <= unpack_lo(entries_q[rd_index][LO1_LSB-1:LO0_LSB]);
                rd_lo1 <= unpack_lo(entries_q[rd_index][TLB_ENTRY_WIDTH-1:LO1_LSB]);
            end
        end
    end

    tlb_probe_match u_probe_match (
        .entries (entries_q),
        .key     (probe_hi),
        .hit     (match_hit),
        .index   (match_index)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe_valid <= 1'b0;
            probe_miss  <= 1'b0;
            probe_index <= '0;
        end else begin
            probe_valid <= probe_req;
            if (probe_req) begin
                probe_miss  <= ~match_hit;
                probe_index <= match_hit ? match_index : '0;
            end
        end
    end

    assign random_o  = random_q;
    assign entries_o = entries_q;

endmodule

// File: tb/tb_tlb_regfile.sv
module tb_tlb_regfile;
    import tlb_regfile_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         we, wr_random, wired_we, rd_req, probe_req;
    TLB_index_t   wr_index, wired_i, rd_index;
    Word_t        wr_hi, wr_lo0, wr_lo1, probe_hi;
    logic         rd_valid, probe_valid, probe_miss;
    Word_t        rd_hi, rd_lo0, rd_lo1;
    TLB_index_t   probe_index, random_o;
    TLB_entries_t entries_o;

    int checks = 0;
    int passed = 0;

    tlb_regfile dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wr_random(wr_random), .wr_index(wr_index),
        .wr_hi(wr_hi), .wr_lo0(wr_lo0), .wr_lo1(wr_lo1), .wired_we(wired_we), .wired_i(wired_i),
        .rd_req(rd_req), .rd_index(rd_index), .rd_valid(rd_valid), .rd_hi(rd_hi),
        .rd_lo0(rd_lo0), .rd_lo1(rd_lo1), .probe_req(probe_req), .probe_hi(probe_hi),
        .probe_valid(probe_valid), .probe_miss(probe_miss), .probe_index(probe_index),
        .random_o(random_o), .entries_o(entries_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        we = 0; wr_random = 0; wr_index = '0; wr_hi = '0; wr_lo0 = '0; wr_lo1 = '0;
        wired_we = 0; wired_i = '0; rd_req = 0; rd_index = '0; probe_req = 0; probe_hi = '0;
    endtask

    // Leaves time #1 after the edge on which reset was held; Random = 15 here.
    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic write_entry(input TLB_index_t idx, input Word_t hi, input Word_t lo0, input Word_t lo1);
        we = 1; wr_random = 0; wr_index = idx; wr_hi = hi; wr_lo0 = lo0; wr_lo1 = lo1;
        tick();
        we = 0;
    endtask

    task automatic do_read(input TLB_index_t idx);
        rd_req = 1; rd_index = idx;
        tick();
        rd_req = 0;
    endtask

    task automatic do_probe(input Word_t hi);
        probe_req = 1; probe_hi = hi;
        tick();
        probe_req = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (random_o !== 4'd15) $display("FAIL reset_random got=%0d exp=15", random_o); else passed++;
        checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); else passed++;
        checks++; if (probe_valid !== 1'b0 || probe_miss !== 1'b0 || probe_index !== 4'd0)
            $display("FAIL reset_probe got=%b%b/%0d exp=00/0", probe_valid, probe_miss, probe_index); else passed++;
        checks++; if ({rd_hi, rd_lo0, rd_lo1} !== 96'd0) $display("FAIL reset_rd_data got=%h exp=0", {rd_hi, rd_lo0, rd_lo1}); else passed++;
        checks++; if (entries_o !== '0) $display("FAIL reset_entries got=%h exp=0", entries_o); else passed++;
    endtask

    task automatic test_random_seq();
        int exp_r;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            exp_r = (k < 16) ? 15 - k : 31 - k;
            checks++;
            if (random_o !== 4'(exp_r)) $display("FAIL random_seq[%0d] got=%0d exp=%0d", k, random_o, exp_r); else passed++;
            tick();
        end
    endtask

    task automatic test_write_read();
        do_reset();
        write_entry(4'd3, 32'h00402001, 32'h00001017, 32'h00001056);
        // lo1 has G=0, so the combined G clears bit 0 of the stored lo0
        checks++; if (entries_o[3] !== {32'h00001056, 32'h00001016, 32'h00402001})
            $display("FAIL entry3_packed got=%h exp=%h", entries_o[3], {32'h00001056, 32'h00001016, 32'h00402001}); else passed++;
        do_read(4'd3);
        checks++; if (rd_valid !== 1'b1) $display("FAIL rd3_valid got=%b exp=1", rd_valid); else passed++;
        checks++; if (rd_hi !== 32'h00402001) $display("FAIL rd3_hi got=%h exp=00402001", rd_hi); else passed++;
        checks++; if (rd_lo0 !== 32'h00001016) $display("FAIL rd3_lo0 got=%h exp=00001016", rd_lo0); else passed++;
        checks++; if (rd_lo1 !== 32'h00001056) $display("FAIL rd3_lo1 got=%h exp=00001056", rd_lo1); else passed++;
        tick();
        checks++; if (rd_valid !== 1'b0) $display("FAIL rd3_pulse got=%b exp=0", rd_valid); else passed++;
        // Top index, all-ones fields: hi[12:8] and lo[31:26] must be dropped
        write_entry(4'd15, 32'hFFFFFFFF, 32'hFC000007, 32'hFFFFFFFF);
        checks++; if (entries_o[15] !== {32'hFFFFFFFF, 32'hFC000007, 32'hFFFFE0FF})
            $display("FAIL entry15_packed got=%h exp=%h", entries_o[15], {32'hFFFFFFFF, 32'hFC000007, 32'hFFFFE0FF}); else passed++;
        do_read(4'd15);
        checks++; if ({rd_hi, rd_lo0, rd_lo1} !== {32'hFFFFE0FF, 32'h00000007, 32'h03FFFFFF})
            $display("FAIL rd15 got=%h exp=%h", {rd_hi, rd_lo0, rd_lo1}, {32'hFFFFE0FF, 32'h00000007, 32'h03FFFFFF}); else passed++;
    endtask

    task automatic test_probe();
        do_reset();
        write_entry(4'd5, 32'h00402011, 32'h00000003, 32'h00000003);
        write_entry(4'd9, 32'h00402022, 32'h00000001, 32'h00000001);
        write_entry(4'd7, 32'h00A00033, 32'h00000002, 32'h00000002);
        do_probe(32'h004020FF);
        checks++; if (probe_valid !== 1'b1 || probe_miss !== 1'b0 || probe_index !== 4'd5)
            $display("FAIL probe_global got=%b%b/%0d exp=10/5", probe_valid, probe_miss, probe_index); else passed++;
        tick();
        checks++; if (probe_valid !== 1'b0) $display("FAIL probe_pulse got=%b exp=0", probe_valid); else passed++;
        do_probe(32'h00800001);
        checks++; if (probe_valid !== 1'b1 || probe_miss !== 1'b1 || probe_index !== 4'd0)
            $display("FAIL probe_miss got=%b%b/%0d exp=11/0", probe_valid, probe_miss, probe_index); else passed++;
        do_probe(32'h00A00033);
        checks++; if (probe_miss !== 1'b0 || probe_index !== 4'd7)
            $display("FAIL probe_asid_hit got=%b/%0d exp=0/7", probe_miss, probe_index); else passed++;
        do_probe(32'h00A00034);
        checks++; if (probe_miss !== 1'b1 || probe_index !== 4'd0)
            $display("FAIL probe_asid_miss got=%b/%0d exp=1/0", probe_miss, probe_index); else passed++;
    endtask

    task automatic test_same_cycle();
        do_reset();
        we = 1; wr_index = 4'd2; wr_hi = 32'h12346055; wr_lo0 = 32'h00000042; wr_lo1 = 32'h00000080;
        probe_req = 1; probe_hi = 32'h12346055;
        rd_req = 1; rd_index = 4'd2;
        tick();
        we = 0; rd_req = 0;
        checks++; if (probe_valid !== 1'b1 || probe_miss !== 1'b1 || probe_index !== 4'd0)
            $display("FAIL wp_same_probe got=%b%b/%0d exp=11/0", probe_valid, probe_miss, probe_index); else passed++;
        checks++; if (rd_valid !== 1'b1 || rd_hi !== 32'h0 || rd_lo0 !== 32'h0)
            $display("FAIL wr_same_read got=%b/%h/%h exp=1/0/0", rd_valid, rd_hi, rd_lo0); else passed++;
        tick();
        probe_req = 0;
        checks++; if (probe_valid !== 1'b1 || probe_miss !== 1'b0 || probe_index !== 4'd2)
            $display("FAIL wp_repeat_probe got=%b%b/%0d exp=10/2", probe_valid, probe_miss, probe_index); else passed++;
    endtask

    task automatic test_tlbwr();
        do_reset();
        tick(); tick(); tick();
        checks++; if (random_o !== 4'd12) $display("FAIL wr_rand_pre got=%0d exp=12", random_o); else passed++;
        we = 1; wr_random = 1; wr_index = 4'd0;
        wr_hi = 32'h0ABCD0AA; wr_lo0 = 32'h00000043; wr_lo1 = 32'h00000081;
        wired_we = 1; wired_i = 4'd4;
        tick();
        we = 0; wr_random = 0; wired_we = 0;
        checks++; if (entries_o[12] !== {32'h00000081, 32'h00000043, 32'h0ABCC0AA})
            $display("FAIL tlbwr_target got=%h exp=%h", entries_o[12], {32'h00000081, 32'h00000043, 32'h0ABCC0AA}); else passed++;
        checks++; if (entries_o[0] !== '0 || entries_o[11] !== '0)
            $display("FAIL tlbwr_other got=%h/%h exp=0/0", entries_o[0], entries_o[11]); else passed++;
`ifdef TLB_WIRED_EN
        checks++; if (random_o !== 4'd15) $display("FAIL tlbwr_rand_post got=%0d exp=15", random_o); else passed++;
`else
        checks++; if (random_o !== 4'd11) $display("FAIL tlbwr_rand_post got=%0d exp=11", random_o); else passed++;
`endif
    endtask

    task automatic test_wired();
        int exp_r;
        do_reset();
        for (int k = 0; k < 6; k++) tick();
        checks++; if (random_o !== 4'd9) $display("FAIL wired_pre got=%0d exp=9", random_o); else passed++;
        wired_we = 1; wired_i = 4'd4;
        tick();
        wired_we = 0;
`ifdef TLB_WIRED_EN
        exp_r = 15;
        for (int k = 0; k < 26; k++) begin
            checks++;
            if (random_o !== 4'(exp_r)) $display("FAIL wired_seq[%0d] got=%0d exp=%0d", k, random_o, exp_r); else passed++;
            exp_r = (exp_r == 4) ? 15 : exp_r - 1;
            tick();
        end
        wired_we = 1; wired_i = 4'd15;
        tick();
        wired_we = 0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (random_o !== 4'd15) $display("FAIL wired15_hold[%0d] got=%0d exp=15", k, random_o); else passed++;
            tick();
        end
`else
        exp_r = 8;
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (random_o !== 4'(exp_r)) $display("FAIL nowired_seq[%0d] got=%0d exp=%0d", k, random_o, exp_r); else passed++;
            exp_r = (exp_r == 0) ? 15 : exp_r - 1;
            tick();
        end
`endif
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        write_entry(4'd6, 32'h00C00011, 32'h00000007, 32'h00000007);
        rd_req = 1; rd_index = 4'd6;
        rst_n = 0;
        tick();
        rd_req = 0;
        rst_n = 1;
        checks++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_valid got=%b exp=0", rd_valid); else passed++;
        tick();
        checks++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_after got=%b exp=0", rd_valid); else passed++;
        do_read(4'd6);
        checks++; if (rd_valid !== 1'b1 || {rd_hi, rd_lo0, rd_lo1} !== 96'd0)
            $display("FAIL rst_rd_data got=%b/%h exp=1/0", rd_valid, {rd_hi, rd_lo0, rd_lo1}); else passed++;
        checks++; if (entries_o !== '0) $display("FAIL rst_entries got=%h exp=0", entries_o); else passed++;
        // A probe response already presented is cleared immediately by reset
        do_probe(32'h00C00011);
        rst_n = 0;
        #1;
        checks++; if (probe_valid !== 1'b0 || probe_miss !== 1'b0) $display("FAIL rst_probe got=%b%b exp=00", probe_valid, probe_miss); else passed++;
        tick();
        rst_n = 1;
        tick();
        checks++; if (probe_valid !== 1'b0) $display("FAIL rst_probe_after got=%b exp=0", probe_valid); else passed++;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_random_seq();
        test_write_read();
        test_probe();
        test_same_cycle();
        test_tlbwr();
        test_wired();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
